obstacle_sprite_engine: RTL and testbench

//   Moves one rectangular obstacle sprite across the 160x120 pixel plotter.
//   - Generates its own frame ticks and step ticks.
//   - On each step: erases the sprite at its old position, moves it (either

---
 rtl/obstacle_sprite_engine.sv | 210 +++++++++++++++++++++
 tb/tb_obstacle_sprite_engine.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_sprite_engine.sv
// Obstacle sprite mover: frame/step timing, erase-move-redraw passes and a
// one-pixel-per-cycle plotter feed for a single rectangular sprite.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   INIT  | first cycle after reset; starts the initial draw (no erase)
//   IDLE  | waiting for a pending step request
//   ERASE | scans the sprite at the old base in BG_COLOUR
//   MOVE  | one cycle; updates base_x (with wrap) and base_y (pending row)
//   DRAW  | scans the sprite at the new base in FG_COLOUR
//   DONE  | one cycle; pulses step_done (and wrapped if the move wrapped)
module obstacle_sprite_engine #(
   parameter int         FRAME_DIV       = 833333,
   parameter int         FRAMES_PER_STEP = 15,
   parameter int         STEP            = 1,
   parameter int         SPR_W           = 4,
   parameter int         SPR_H           = 4,
   parameter int         SCREEN_W        = 160,
   parameter int         SCREEN_H        = 120,
   parameter int         START_X         = 10,
   parameter int         START_Y         = 58,
   parameter logic [2:0] FG_COLOUR       = 3'd2,
   parameter logic [2:0] BG_COLOUR       = 3'd0
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       enable,
   input  logic       dir,
   input  logic       load_y,
   input  logic [6:0] y_in,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       step_done,
   output logic       wrapped
);

   localparam int DLY_W  = $clog2(FRAME_DIV + 1);
   localparam int FCNT_W = $clog2(FRAMES_PER_STEP + 1);
   localparam int XMAX   = SCREEN_W - SPR_W;
   localparam int YMAX   = SCREEN_H - SPR_H;

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_ERASE, S_MOVE, S_DRAW, S_DONE
   } state_t;

   state_t state, state_next;

   logic [DLY_W-1:0]  dly;
   logic [FCNT_W-1:0] fcnt;
   logic              frame_tick, step_tick;
   logic              step_pend;
   logic [6:0]        ypend;
   logic              ypend_v;
   logic [3:0]        px, py, px_next, py_next;
   logic [7:0]        base_x, base_x_next;
   logic [6:0]        base_y, base_y_next;
   logic              wrap_flag, wrap_next;
   logic              scan_last;
   logic [8:0]        bx9, sum9;
   logic              plot_d;
   logic [2:0]        colour_d;
   logic [7:0]        x_d;
   logic [6:0]        y_d;

   assign frame_tick = enable && (dly == '0);
   assign step_tick  = frame_tick && (fcnt == FCNT_W'(FRAMES_PER_STEP - 1));

   always_ff @(posedge clock) begin
      if (!resetn) begin
         dly  <= '0;
         fcnt <= '0;
      end else if (enable) begin
         if (dly == '0) begin
            dly <= DLY_W'(FRAME_DIV - 1);
            if (fcnt == FCNT_W'(FRAMES_PER_STEP - 1))
               fcnt <= '0;
            else
               fcnt <= fcnt + 1'b1;
         end else begin
            dly <= dly - 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn)
         state <= S_INIT;
      else
         state <= state_next;
   end

   assign bx9       = {1'b0, base_x};
   assign sum9      = bx9 + 9'(STEP);
   assign scan_last = (px == 4'(SPR_W - 1)) && (py == 4'(SPR_H - 1));

   always_comb begin
      state_next  = state;
      px_next     = px;
      py_next     = py;
      base_x_next = base_x;
      base_y_next = base_y;
      wrap_next   = wrap_flag;
      case (state)
         S_INIT: begin
            state_next = S_DRAW;
            px_next    = '0;
            py_next    = '0;
            wrap_next  = 1'b0;
         end
         S_IDLE: begin
            if (step_pend) begin
               state_next = S_ERASE;
               px_next    = '0;
               py_next    = '0;
               wrap_next  = 1'b0;
            end
         end
         S_ERASE, S_DRAW: begin
            if (scan_last) begin
               state_next = (state == S_ERASE) ? S_MOVE : S_DONE;
               px_next    = '0;
               py_next    = '0;
            end else if (px == 4'(SPR_W - 1)) begin
               px_next = '0;
               py_next = py + 4'd1;
            end else begin
               px_next = px + 4'd1;
            end
         end
         S_MOVE: begin
            state_next = S_DRAW;
            if (!dir) begin
               if (sum9 > 9'(XMAX)) begin
                  base_x_next = '0;
                  wrap_next   = 1'b1;
               end else begin
                  base_x_next = sum9[7:0];
               end
            end else begin
               if (bx9 < 9'(STEP)) begin
                  base_x_next = 8'(XMAX);
                  wrap_next   = 1'b1;
               end else begin
                  base_x_next = 8'(bx9 - 9'(STEP));
               end
            end
            if (ypend_v)
               base_y_next = (ypend > 7'(YMAX)) ? 7'(YMAX) : ypend;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_INIT;
      endcase
   end

   // Plot outputs are computed from next-cycle values so the registered
   // pixel lines up exactly with the cycle the FSM spends in ERASE/DRAW.
   always_comb begin
      plot_d    = (state_next == S_ERASE) || (state_next == S_DRAW);
      colour_d  = (state_next == S_DRAW) ? FG_COLOUR : BG_COLOUR;
      x_d       = base_x_next + {4'd0, px_next};
      y_d       = base_y_next + {3'd0, py_next};
      busy      = (state == S_ERASE) || (state == S_MOVE) ||
                  (state == S_DRAW)  || (state == S_DONE);
      step_done = (state == S_DONE);
      wrapped   = (state == S_DONE) && wrap_flag;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         px        <= '0;
         py        <= '0;
         base_x    <= 8'(START_X);
         base_y    <= 7'(START_Y);
         wrap_flag <= 1'b0;
         step_pend <= 1'b0;
         ypend     <= '0;
         ypend_v   <= 1'b0;
         x         <= '0;
         y         <= '0;
         colour    <= BG_COLOUR;
         plot      <= 1'b0;
      end else begin
         px        <= px_next;
         py        <= py_next;
         base_x    <= base_x_next;
         base_y    <= base_y_next;
         wrap_flag <= wrap_next;
         x         <= x_d;
         y         <= y_d;
         colour    <= colour_d;
         plot      <= plot_d;
         // A new tick wins over the clear so a request landing on the
         // IDLE->ERASE edge is not lost.
         if (state == S_IDLE && step_pend)
            step_pend <= 1'b0;
         if (step_tick)
            step_pend <= 1'b1;
         if (state == S_MOVE)
            ypend_v <= 1'b0;
         if (load_y) begin
            ypend   <= y_in;
            ypend_v <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_obstacle_sprite_engine.sv
// Directed bench for obstacle_sprite_engine with fast frame timing
// (FRAME_DIV=4, FRAMES_PER_STEP=2); each pass is captured then checked.
module tb_obstacle_sprite_engine;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       enable = 1'b0;
   logic       dir = 1'b0;
   logic       load_y = 1'b0;
   logic [6:0] y_in = '0;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot, busy, step_done, wrapped;

   int tests_run = 0;
   int tests_failed = 0;

   logic [7:0] cap_x [35];
   logic [6:0] cap_y [35];
   logic [2:0] cap_c [35];
   logic       cap_p [35];
   logic       cap_b [35];
   logic       cap_sd[35];
   logic       cap_w [35];
   int         cap_wait;
   int         bx;

   obstacle_sprite_engine #(.FRAME_DIV(4), .FRAMES_PER_STEP(2)) dut (
      .clock(clock), .resetn(resetn), .enable(enable), .dir(dir),
      .load_y(load_y), .y_in(y_in), .x(x), .y(y), .colour(colour),
      .plot(plot), .busy(busy), .step_done(step_done), .wrapped(wrapped)
   );

   always #5 clock = ~clock;

   // Waits (bounded) for the first plot cycle, then records 35 cycles:
   // 0..15 first scan, 16 MOVE/DONE, 17..32 draw, 33 DONE, 34 IDLE.
   task automatic capture_pass(input int load_at, input logic [6:0] load_val);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (plot !== 1'b1 && n < 200);
      cap_wait = n;
      tests_run++;
      if (plot !== 1'b1) begin
         tests_failed++;
         $display("FAIL capture_timeout: plot=%b after %0d cycles, required 1", plot, n);
      end
      for (int i = 0; i < 35; i++) begin
         if (i > 0) @(negedge clock);
         load_y    = 1'b0;
         cap_x[i]  = x;
         cap_y[i]  = y;
         cap_c[i]  = colour;
         cap_p[i]  = plot;
         cap_b[i]  = busy;
         cap_sd[i] = step_done;
         cap_w[i]  = wrapped;
         if (i == load_at) begin
            y_in   = load_val;
            load_y = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      tests_run++;
      if (plot !== 1'b0 || busy !== 1'b0 || step_done !== 1'b0 || wrapped !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: plot=%b busy=%b step_done=%b wrapped=%b, required all 0",
                  plot, busy, step_done, wrapped);
      end
      tests_run++;
      if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_xyc: x=%0d y=%0d colour=%0d, required 0 0 0", x, y, colour);
      end
   endtask

   task automatic test_init_draw();
      resetn = 1'b1;
      capture_pass(-1, 7'd0);
      tests_run++;
      if (cap_wait != 1) begin
         tests_failed++;
         $display("FAIL init_latency: first plot after %0d cycles, required 1", cap_wait);
      end
      for (int i = 0; i < 16; i++) begin
         tests_run++;
         if (cap_p[i] !== 1'b1 || cap_c[i] !== 3'd2 || cap_b[i] !== 1'b1 ||
             cap_x[i] !== 8'(10 + i % 4) || cap_y[i] !== 7'(58 + i / 4)) begin
            tests_failed++;
            $display("FAIL init_pixel%0d: p=%b c=%0d x=%0d y=%0d, required 1 2 %0d %0d",
                     i, cap_p[i], cap_c[i], cap_x[i], cap_y[i], 10 + i % 4, 58 + i / 4);
         end
      end
      tests_run++;
      if (cap_sd[16] !== 1'b1 || cap_p[16] !== 1'b0 || cap_w[16] !== 1'b0) begin
         tests_failed++;
         $display("FAIL init_done: step_done=%b plot=%b wrapped=%b, required 1 0 0",
                  cap_sd[16], cap_p[16], cap_w[16]);
      end
      for (int i = 17; i < 35; i++) begin
         tests_run++;
         if (cap_p[i] !== 1'b0 || cap_b[i] !== 1'b0 || cap_sd[i] !== 1'b0) begin
            tests_failed++;
            $display("FAIL init_idle%0d: plot=%b busy=%b step_done=%b, required 0 0 0",
                     i, cap_p[i], cap_b[i], cap_sd[i]);
         end
      end
   endtask

   task automatic test_step_right();
      int nbusy = 0;
      dir    = 1'b0;
      enable = 1'b1;
      capture_pass(-1, 7'd0);
      tests_run++;
      if (cap_wait != 6) begin
         tests_failed++;
         $display("FAIL step_latency: first erase after %0d cycles, required 6", cap_wait);
      end
      for (int i = 0; i < 16; i++) begin
         tests_run++;
         if (cap_p[i] !== 1'b1 || cap_c[i] !== 3'd0 ||
             cap_x[i] !== 8'(10 + i % 4) || cap_y[i] !== 7'(58 + i / 4)) begin
            tests_failed++;
            $display("FAIL step_erase%0d: p=%b c=%0d x=%0d y=%0d, required 1 0 %0d %0d",
                     i, cap_p[i], cap_c[i], cap_x[i], cap_y[i], 10 + i % 4, 58 + i / 4);
         end
         tests_run++;
         if (cap_p[17+i] !== 1'b1 || cap_c[17+i] !== 3'd2 ||
             cap_x[17+i] !== 8'(11 + i % 4) || cap_y[17+i] !== 7'(58 + i / 4)) begin
            tests_failed++;
            $display("FAIL step_draw%0d: p=%b c=%0d x=%0d y=%0d, required 1 2 %0d %0d",
                     i, cap_p[17+i], cap_c[17+i], cap_x[17+i], cap_y[17+i], 11 + i % 4, 58 + i / 4);
         end
      end
      tests_run++;
      if (cap_p[16] !== 1'b0 || cap_b[16] !== 1'b1 || cap_sd[16] !== 1'b0) begin
         tests_failed++;
         $display("FAIL step_move: plot=%b busy=%b step_done=%b, required 0 1 0",
                  cap_p[16], cap_b[16], cap_sd[16]);
      end
      tests_run++;
      if (cap_sd[33] !== 1'b1 || cap_w[33] !== 1'b0 || cap_p[33] !== 1'b0) begin
         tests_failed++;
         $display("FAIL step_done: step_done=%b wrapped=%b plot=%b, required 1 0 0",
                  cap_sd[33], cap_w[33], cap_p[33]);
      end
      for (int i = 0; i < 35; i++) nbusy += int'(cap_b[i]);
      tests_run++;
      if (nbusy != 34 || cap_b[34] !== 1'b0) begin
         tests_failed++;
         $display("FAIL step_busy: busy cycles=%0d last=%b, required 34 0", nbusy, cap_b[34]);
      end
      bx = 11;
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 2; k++) begin
         capture_pass(-1, 7'd0);
         tests_run++;
         if (cap_wait != 1 || cap_p[34] !== 1'b0 || cap_sd[34] !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_gap%0d: wait=%0d idle_plot=%b idle_done=%b, required 1 0 0",
                     k, cap_wait, cap_p[34], cap_sd[34]);
         end
         tests_run++;
         if (cap_x[0] !== 8'(bx) || cap_c[0] !== 3'd0 ||
             cap_x[17] !== 8'(bx + 1) || cap_c[17] !== 3'd2) begin
            tests_failed++;
            $display("FAIL b2b_pos%0d: erase x=%0d c=%0d draw x=%0d c=%0d, required %0d 0 %0d 2",
                     k, cap_x[0], cap_c[0], cap_x[17], cap_c[17], bx, bx + 1);
         end
         bx++;
      end
   endtask

   task automatic test_wrap();
      dir = 1'b1;
      while (bx != 0) begin
         capture_pass(-1, 7'd0);
         bx--;
         tests_run++;
         if (cap_x[17] !== 8'(bx) || cap_w[33] !== 1'b0 || cap_sd[33] !== 1'b1) begin
            tests_failed++;
            $display("FAIL left_step_x%0d: draw x=%0d wrapped=%b done=%b, required %0d 0 1",
                     bx, cap_x[17], cap_w[33], cap_sd[33], bx);
         end
      end
      capture_pass(-1, 7'd0);
      tests_run++;
      if (cap_x[0] !== 8'd0 || cap_x[17] !== 8'd156 || cap_x[32] !== 8'd159) begin
         tests_failed++;
         $display("FAIL left_wrap_x: erase x=%0d draw x=%0d..%0d, required 0 156..159",
                  cap_x[0], cap_x[17], cap_x[32]);
      end
      tests_run++;
      if (cap_w[33] !== 1'b1 || cap_sd[33] !== 1'b1 || cap_w[34] !== 1'b0) begin
         tests_failed++;
         $display("FAIL left_wrap_flag: wrapped=%b done=%b next_wrapped=%b, required 1 1 0",
                  cap_w[33], cap_sd[33], cap_w[34]);
      end
      dir = 1'b0;
      capture_pass(-1, 7'd0);
      tests_run++;
      if (cap_x[0] !== 8'd156 || cap_x[17] !== 8'd0 || cap_x[32] !== 8'd3 || cap_w[33] !== 1'b1) begin
         tests_failed++;
         $display("FAIL right_wrap: erase x=%0d draw x=%0d..%0d wrapped=%b, required 156 0..3 1",
                  cap_x[0], cap_x[17], cap_x[32], cap_w[33]);
      end
      bx = 0;
   endtask

   task automatic test_load_y();
      capture_pass(3, 7'd127);
      tests_run++;
      if (cap_y[0] !== 7'd58 || cap_y[15] !== 7'd61) begin
         tests_failed++;
         $display("FAIL loady_erase_rows: y=%0d..%0d, required 58..61", cap_y[0], cap_y[15]);
      end
      tests_run++;
      if (cap_y[17] !== 7'd116 || cap_y[32] !== 7'd119 || cap_x[17] !== 8'd1) begin
         tests_failed++;
         $display("FAIL loady_clamp: draw y=%0d..%0d x=%0d, required 116..119 1",
                  cap_y[17], cap_y[32], cap_x[17]);
      end
      capture_pass(16, 7'd20);
      tests_run++;
      if (cap_y[17] !== 7'd116 || cap_x[17] !== 8'd2) begin
         tests_failed++;
         $display("FAIL loady_in_move: draw y=%0d x=%0d, required 116 2", cap_y[17], cap_x[17]);
      end
      capture_pass(-1, 7'd0);
      tests_run++;
      if (cap_y[0] !== 7'd116 || cap_y[17] !== 7'd20 || cap_y[32] !== 7'd23) begin
         tests_failed++;
         $display("FAIL loady_deferred: erase y=%0d draw y=%0d..%0d, required 116 20..23",
                  cap_y[0], cap_y[17], cap_y[32]);
      end
   endtask

   task automatic test_reset_mid_draw();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!(plot === 1'b1 && colour === 3'd2) && n < 200);
      tests_run++;
      if (plot !== 1'b1 || colour !== 3'd2) begin
         tests_failed++;
         $display("FAIL rst_find_draw: plot=%b colour=%0d, required 1 2", plot, colour);
      end
      resetn = 1'b0;
      enable = 1'b0;
      @(negedge clock);
      tests_run++;
      if (plot !== 1'b0 || busy !== 1'b0 || x !== 8'd0 || step_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_abort: plot=%b busy=%b x=%0d step_done=%b, required 0 0 0 0",
                  plot, busy, x, step_done);
      end
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      capture_pass(-1, 7'd0);
      tests_run++;
      if (cap_wait != 1 || cap_x[0] !== 8'd10 || cap_y[0] !== 7'd58 ||
          cap_c[0] !== 3'd2 || cap_sd[16] !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_redraw: wait=%0d x=%0d y=%0d c=%0d done=%b, required 1 10 58 2 1",
                  cap_wait, cap_x[0], cap_y[0], cap_c[0], cap_sd[16]);
      end
   endtask

   initial begin
      test_reset();
      test_init_draw();
      test_step_right();
      test_back_to_back();
      test_wrap();
      test_load_y();
      test_reset_mid_draw();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
